ngprc: RTL and testbench
========================

Name: ngprc

Overview:
- Next-grant precalculation block for an 8-channel round-robin arbiter.
- From the current request vector and the current one-hot grant, it combinationally produces the candidate mask for the next arbitration round.
  - The mask contains requesters strictly above the current grant.
  - If no requester sits above the current grant, the mask wraps around to all requesters.
- A small registered status word carries five scan chains and an optional debug port.

Parameters:
- CHANNELS, 8, number of requesters; legal range 2..8. The status index is 3 bits wide, zero-extended.

Ports:
- clk  in  1  system clock; all flops are rising-edge.
- reset  in  1  synchronous, active-high reset.
- request  in  CHANNELS  request vector; bit i high means channel i requests.
- grant  in  CHANNELS  current grant, nominally one-hot; all-zero means no current grant.
- nextGrant  out  CHANNELS  precalculated candidate mask (combinational).
- scan_enable  in  1  scan shift enable; honoured only when test_mode=1.
- test_mode  in  1  test mode select.
- scan_in0..scan_in4  in  1 each  serial inputs of scan chains 0..4.
- scan_out0..scan_out4  out  1 each  serial outputs of scan chains 0..4.
- debugPreCal  out  5  status word; present only with NGPRC_DEBUG_EN.

Behaviour:
- Grant position g is the index of the highest set bit of grant. A multi-hot grant is therefore treated by its highest bit.
- above_mask has bits g+1..CHANNELS-1 set; it is all-zero when g = CHANNELS-1. When grant == 0, above_mask is treated as all-zero.
- masked = request & above_mask.
- nextGrant:
  - nextGrant = masked when masked != 0.
  - Otherwise nextGrant = request (wrap-around).
  - request == 0 gives nextGrant == 0, regardless of grant.
- nextGrant is purely combinational from request and grant:
  - zero-cycle latency; valid within the same clock phase;
  - independent of clk and reset;
  - not cleared by reset.
- Status register status_q[4:0], updated every rising clk:
  - bit 4 = wrap: masked == 0 and request != 0;
  - bit 3 = any: request != 0;
  - bits 2:0 = index of the lowest set bit of nextGrant, or 0 when nextGrant == 0.
- Reset: when reset=1 at a rising edge, status_q <= 0. Reset has priority over functional update. Scan shift has priority over reset.
- Scan:
  - When test_mode=1 and scan_enable=1, each rising edge loads status_q[k] <= scan_in k, for k = 0..4.
  - Each chain is one flop long; scan_outk = status_q[k] at all times.
  - When test_mode=0, scan_enable is ignored.
- No handshake; the block has no internal state affecting nextGrant.

Optional Feature:
- Macro NGPRC_DEBUG_EN.
  - Defined: output port debugPreCal[4:0] is present and driven by status_q.
  - Undefined: the port is absent. status_q and the scan chains remain, and their behaviour is identical.

Test Plan:
- request=8'h00, grant=8'h00 → nextGrant=8'h00; request=8'h00, grant=8'h01 → nextGrant=8'h00.
- request=8'hFF with grant=8'h01 / 8'h02 / 8'h04 → nextGrant=8'hFE / 8'hFC / 8'hF8, checked half a cycle after the input change.
- request=8'hFF, grant=8'h80 → nextGrant=8'hFF (wrap); next edge status_q=5'b11000.
- request=8'h02, grant=8'h02 → nextGrant=8'h02 (wrap to self); request=8'h02, grant=8'h00 → nextGrant=8'h02; status_q index=1.
- Reset asserted for one edge with request=8'hFF, grant=8'h80 → status_q=0, while nextGrant stays 8'hFF throughout.
- test_mode=1, scan_enable=1, scan_in0..4=1,0,1,0,1 for one edge → scan_out0..4=1,0,1,0,1. Repeating with test_mode=0 gives functional status_q instead.

Source files
------------

// File: rtl/ngprc.sv
// Next-grant precalculation for a round-robin arbiter, with a scan-accessible status register.
// Define NGPRC_DEBUG_EN to expose the status register on the debugPreCal port.
module ngprc #(
    parameter int CHANNELS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] request,
    input  logic [CHANNELS-1:0] grant,
    output logic [CHANNELS-1:0] nextGrant,
    input  logic                scan_enable,
    input  logic                test_mode,
    input  logic                scan_in0,
    input  logic                scan_in1,
    input  logic                scan_in2,
    input  logic                scan_in3,
    input  logic                scan_in4,
    output logic                scan_out0,
    output logic                scan_out1,
    output logic                scan_out2,
    output logic                scan_out3,
    output logic                scan_out4
`ifdef NGPRC_DEBUG_EN
    ,
    output logic [4:0]          debugPreCal
`endif
);

    logic [CHANNELS-1:0] above_mask;
    logic [CHANNELS-1:0] masked;
    logic                grant_seen;
    logic [2:0]          low_index;
    logic                wrap;
    logic                any_request;
    logic [4:0]          status_q;
    logic [4:0]          status_d;

    // Bit i of above_mask is set when no grant bit sits at or above i, i.e. i is above the highest grant.
    always_comb begin
        above_mask = '0;
        grant_seen = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            grant_seen    = grant_seen | grant[i];
            above_mask[i] = ~grant_seen;
        end
        if (grant == '0) begin
            above_mask = '0;
        end
    end

    assign masked      = request & above_mask;
    assign any_request = |request;
    assign wrap        = (masked == '0) && any_request;
    assign nextGrant   = (masked != '0) ? masked : request;

    always_comb begin
        low_index = 3'd0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (nextGrant[i]) begin
                low_index = 3'(i);
            end
        end
    end

    assign status_d = {wrap, any_request, low_index};

    // Scan shift outranks reset so the chains can be loaded while the system is held in reset.
    always_ff @(posedge clk) begin
        if (test_mode && scan_enable) begin
            status_q <= {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
        end else if (reset) begin
            status_q <= 5'd0;
        end else begin
            status_q <= status_d;
        end
    end

    assign scan_out0 = status_q[0];
    assign scan_out1 = status_q[1];
    assign scan_out2 = status_q[2];
    assign scan_out3 = status_q[3];
    assign scan_out4 = status_q[4];

`ifdef NGPRC_DEBUG_EN
    assign debugPreCal = status_q;
`endif

endmodule

// File: tb/tb_ngprc.sv
// Directed self-checking bench for ngprc: combinational next-grant mask, status register, reset and scan.
module tb_ngprc;

    logic       clk;
    logic       reset;
    logic [7:0] request;
    logic [7:0] grant;
    logic [7:0] nextGrant;
    logic       scan_enable;
    logic       test_mode;
    logic       scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic       scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic [4:0] scanOut;
`ifdef NGPRC_DEBUG_EN
    logic [4:0] debugPreCal;
`endif

    int checks = 0;
    int errors = 0;

    ngprc #(.CHANNELS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .grant       (grant),
        .nextGrant   (nextGrant),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
`ifdef NGPRC_DEBUG_EN
        ,
        .debugPreCal (debugPreCal)
`endif
    );

    assign scanOut = {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Change inputs just after a rising edge, then stop on the falling edge half a cycle later.
    task automatic applyStimulus(input logic [7:0] req, input logic [7:0] gnt);
        @(posedge clk);
        #1;
        request = req;
        grant   = gnt;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Let one rising edge capture the current inputs, then compare the status word.
    task automatic checkStatus(input string tag, input logic [4:0] expected);
        @(posedge clk);
        #1;
        checkOutput(tag, {3'b000, scanOut}, {3'b000, expected});
`ifdef NGPRC_DEBUG_EN
        checkOutput({tag, "_dbg"}, {3'b000, debugPreCal}, {3'b000, expected});
`endif
    endtask

    initial begin
        reset       = 1'b1;
        request     = 8'h00;
        grant       = 8'h00;
        scan_enable = 1'b0;
        test_mode   = 1'b0;
        {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b00000;

        @(posedge clk);
        #1;
        checkOutput("reset_status", {3'b000, scanOut}, 8'h00);
        reset = 1'b0;

        applyStimulus(8'h00, 8'h00);
        checkOutput("ng_req0_gnt0", nextGrant, 8'h00);
        checkStatus("st_idle", 5'b00000);

        applyStimulus(8'h00, 8'h01);
        checkOutput("ng_req0_gnt1", nextGrant, 8'h00);

        applyStimulus(8'hFF, 8'h01);
        checkOutput("ng_ff_g01", nextGrant, 8'hFE);
        applyStimulus(8'hFF, 8'h02);
        checkOutput("ng_ff_g02", nextGrant, 8'hFC);
        applyStimulus(8'hFF, 8'h04);
        checkOutput("ng_ff_g04", nextGrant, 8'hF8);
        checkStatus("st_ff_g04", 5'b01011);

        applyStimulus(8'hFF, 8'h80);
        checkOutput("ng_ff_g80_wrap", nextGrant, 8'hFF);
        checkStatus("st_ff_g80", 5'b11000);

        applyStimulus(8'h02, 8'h02);
        checkOutput("ng_self_wrap", nextGrant, 8'h02);
        checkStatus("st_self_wrap", 5'b11001);

        applyStimulus(8'h02, 8'h00);
        checkOutput("ng_nogrant", nextGrant, 8'h02);
        checkStatus("st_nogrant", 5'b11001);

        applyStimulus(8'h0F, 8'h12);
        checkOutput("ng_multihot", nextGrant, 8'h0F);
        checkStatus("st_multihot", 5'b11000);

        applyStimulus(8'hA5, 8'h09);
        checkOutput("ng_a5_g09", nextGrant, 8'hA0);
        checkStatus("st_a5_g09", 5'b01101);

        // Reset clears the status word but leaves the combinational mask alone.
        applyStimulus(8'hFF, 8'h80);
        reset = 1'b1;
        #1;
        checkOutput("ng_in_reset", nextGrant, 8'hFF);
        checkStatus("st_reset", 5'b00000);
        checkOutput("ng_after_reset_edge", nextGrant, 8'hFF);
        reset = 1'b0;
        checkStatus("st_after_reset", 5'b11000);

        // Scan load, held in reset at the same edge to show scan wins.
        test_mode   = 1'b1;
        scan_enable = 1'b1;
        reset       = 1'b1;
        {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b10101;
        checkStatus("st_scan_load", 5'b10101);
        checkOutput("ng_during_scan", nextGrant, 8'hFF);

        {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b01010;
        reset = 1'b0;
        checkStatus("st_scan_load2", 5'b01010);

        // Without test_mode the scan enable is ignored and the functional value returns.
        test_mode = 1'b0;
        {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = 5'b10101;
        checkStatus("st_scan_ignored", 5'b11000);

        scan_enable = 1'b0;
        applyStimulus(8'h40, 8'h08);
        checkOutput("ng_40_g08", nextGrant, 8'h40);
        checkStatus("st_40_g08", 5'b01110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
